axis_frame_len_check: RTL and testbench

AXIS_FRAME_LEN_CHECK -- requirements
Module: axis_frame_len_check

---
 rtl/axis_pkg.sv | 15 +
 rtl/axis_reg_stage.sv | 49 ++++
 rtl/axis_frame_len_check.sv | 154 +++++++++++++++
 tb/tb_axis_frame_len_check.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pkg.sv
// Shared types and default widths for the AXI-stream frame length checker.
package axis_pkg;

  // PASS forwards beats; DROP swallows the tail of a truncated frame.
  typedef enum logic {
    ST_PASS = 1'b0,
    ST_DROP = 1'b1
  } len_state_t;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_LEN_WIDTH  = 16;
  localparam int DEF_MIN_LEN    = 2;
  localparam int DEF_MAX_LEN    = 4;

endpackage

// File: rtl/axis_reg_stage.sv
// Single-entry AXI-stream register slice; accepts a new beat in the same
// cycle the held beat leaves, so it sustains one beat per cycle.
module axis_reg_stage #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] i_tdata,
  input  logic                  i_tvalid,
  input  logic                  i_tlast,
  input  logic                  i_tuser,
  output logic                  o_ready,
  output logic [DATA_WIDTH-1:0] o_tdata,
  output logic                  o_tvalid,
  output logic                  o_tlast,
  output logic                  o_tuser,
  input  logic                  i_tready
);

  logic [DATA_WIDTH-1:0] r_tdata;
  logic                  r_tvalid;
  logic                  r_tlast;
  logic                  r_tuser;

  // Room for a beat when empty or when the held beat is leaving this cycle.
  assign o_ready  = i_tready || !r_tvalid;
  assign o_tdata  = r_tdata;
  assign o_tvalid = r_tvalid;
  assign o_tlast  = r_tlast;
  assign o_tuser  = r_tuser;

  // Load on accept, drop valid once the downstream takes the held beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_tuser  <= 1'b0;
    end else if (i_tvalid && o_ready) begin
      r_tdata  <= i_tdata;
      r_tvalid <= 1'b1;
      r_tlast  <= i_tlast;
      r_tuser  <= i_tuser;
    end else if (i_tready) begin
      r_tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/axis_frame_len_check.sv
// AXI-stream frame length checker: forwards frames through one register
// stage, truncates frames longer than MAX_LEN (marking the cut beat with
// tlast+tuser and discarding the rest), flags short or tuser-tainted frames,
// and reports each frame's forwarded length with a one-cycle status pulse.
// Optional macro AXIS_LEN_STATS_EN adds saturating good/bad frame counters.
module axis_frame_len_check
  import axis_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
  parameter int MIN_LEN    = DEF_MIN_LEN,
  parameter int MAX_LEN    = DEF_MAX_LEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] input_axis_tdata,
  input  logic                  input_axis_tvalid,
  output logic                  input_axis_tready,
  input  logic                  input_axis_tlast,
  input  logic                  input_axis_tuser,
  output logic [DATA_WIDTH-1:0] output_axis_tdata,
  output logic                  output_axis_tvalid,
  input  logic                  output_axis_tready,
  output logic                  output_axis_tlast,
  output logic                  output_axis_tuser,
  output logic [LEN_WIDTH-1:0]  frame_len,
  output logic                  frame_len_valid,
  output logic                  frame_bad
`ifdef AXIS_LEN_STATS_EN
  ,
  output logic [31:0]           good_count,
  output logic [31:0]           bad_count
`endif
);

  localparam logic [LEN_WIDTH-1:0] CNT_SAT = '1;
  localparam logic [LEN_WIDTH-1:0] MIN_L   = LEN_WIDTH'(MIN_LEN);
  localparam logic [LEN_WIDTH-1:0] MAX_L   = LEN_WIDTH'(MAX_LEN);

  len_state_t           r_state;
  logic [LEN_WIDTH-1:0] r_cnt;
  logic                 r_user_acc;
  logic [LEN_WIDTH-1:0] r_frame_len;
  logic                 r_len_vld;
  logic                 r_bad;

  logic                 w_stage_ready;
  logic                 w_tready;
  logic                 w_accept;
  logic                 w_pass_beat;
  logic [LEN_WIDTH-1:0] w_beat_num;
  logic                 w_trunc;
  logic                 w_end;
  logic                 w_frame_bad;
  logic                 w_out_last;
  logic                 w_out_user;

  // Ordinal of the beat being offered, saturating so it can never wrap.
  assign w_beat_num  = (r_cnt == CNT_SAT) ? r_cnt : r_cnt + LEN_WIDTH'(1);

  // DROP sinks beats unconditionally; PASS follows the output slice.
  assign w_tready    = !rst && ((r_state == ST_DROP) || w_stage_ready);
  assign w_accept    = input_axis_tvalid && w_tready;
  assign w_pass_beat = w_accept && (r_state == ST_PASS);

  // Cut the frame on beat MAX_LEN unless it is the genuine last beat.
  assign w_trunc     = w_pass_beat && !input_axis_tlast && (w_beat_num >= MAX_L);
  assign w_end       = w_pass_beat && input_axis_tlast;
  assign w_frame_bad = (w_beat_num < MIN_L) || r_user_acc || input_axis_tuser;
  assign w_out_last  = input_axis_tlast || w_trunc;
  assign w_out_user  = w_trunc || (input_axis_tlast && w_frame_bad);

  assign input_axis_tready = w_tready;
  assign frame_len         = r_frame_len;
  assign frame_len_valid   = r_len_vld;
  assign frame_bad         = r_bad;

  axis_reg_stage #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out (
    .clk      (clk),
    .rst      (rst),
    .i_tdata  (input_axis_tdata),
    .i_tvalid (w_pass_beat),
    .i_tlast  (w_out_last),
    .i_tuser  (w_out_user),
    .o_ready  (w_stage_ready),
    .o_tdata  (output_axis_tdata),
    .o_tvalid (output_axis_tvalid),
    .o_tlast  (output_axis_tlast),
    .o_tuser  (output_axis_tuser),
    .i_tready (output_axis_tready)
  );

  // Frame FSM, beat counter, tuser accumulator and status pulse generation.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_PASS;
      r_cnt       <= '0;
      r_user_acc  <= 1'b0;
      r_frame_len <= '0;
      r_len_vld   <= 1'b0;
      r_bad       <= 1'b0;
    end else begin
      r_len_vld <= 1'b0;
      r_bad     <= 1'b0;
      if (w_accept) begin
        case (r_state)
          ST_PASS: begin
            if (w_end || w_trunc) begin
              r_cnt       <= '0;
              r_user_acc  <= 1'b0;
              r_frame_len <= w_beat_num;
              r_len_vld   <= 1'b1;
              r_bad       <= w_trunc || w_frame_bad;
              r_state     <= w_trunc ? ST_DROP : ST_PASS;
            end else begin
              r_cnt      <= w_beat_num;
              r_user_acc <= r_user_acc || input_axis_tuser;
            end
          end
          ST_DROP: begin
            // Status for this frame already went out at the cut beat.
            if (input_axis_tlast) r_state <= ST_PASS;
          end
          default: r_state <= ST_PASS;
        endcase
      end
    end
  end

`ifdef AXIS_LEN_STATS_EN
  logic [31:0] r_good_count;
  logic [31:0] r_bad_count;

  assign good_count = r_good_count;
  assign bad_count  = r_bad_count;

  // Saturating per-frame tallies, stepped by each status pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_good_count <= '0;
      r_bad_count  <= '0;
    end else if (r_len_vld) begin
      if (r_bad) begin
        if (r_bad_count != 32'hFFFF_FFFF) r_bad_count <= r_bad_count + 32'd1;
      end else begin
        if (r_good_count != 32'hFFFF_FFFF) r_good_count <= r_good_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_axis_frame_len_check.sv
// Directed + randomized bench for axis_frame_len_check with a frame-level
// reference model (expected beats and status derived per whole frame).
module tb_axis_frame_len_check;

  localparam int DW   = 8;
  localparam int LW   = 16;
  localparam int MINL = 2;
  localparam int MAXL = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in_tdata;
  logic          in_tvalid;
  logic          in_tready;
  logic          in_tlast;
  logic          in_tuser;
  logic [DW-1:0] out_tdata;
  logic          out_tvalid;
  logic          out_tready;
  logic          out_tlast;
  logic          out_tuser;
  logic [LW-1:0] frame_len;
  logic          frame_len_valid;
  logic          frame_bad;
`ifdef AXIS_LEN_STATS_EN
  logic [31:0]   good_count;
  logic [31:0]   bad_count;
`endif

  always #5 clk = ~clk;

  axis_frame_len_check #(
    .DATA_WIDTH (DW),
    .LEN_WIDTH  (LW),
    .MIN_LEN    (MINL),
    .MAX_LEN    (MAXL)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .input_axis_tdata   (in_tdata),
    .input_axis_tvalid  (in_tvalid),
    .input_axis_tready  (in_tready),
    .input_axis_tlast   (in_tlast),
    .input_axis_tuser   (in_tuser),
    .output_axis_tdata  (out_tdata),
    .output_axis_tvalid (out_tvalid),
    .output_axis_tready (out_tready),
    .output_axis_tlast  (out_tlast),
    .output_axis_tuser  (out_tuser),
    .frame_len          (frame_len),
    .frame_len_valid    (frame_len_valid),
    .frame_bad          (frame_bad)
`ifdef AXIS_LEN_STATS_EN
    ,
    .good_count         (good_count),
    .bad_count          (bad_count)
`endif
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic          user;
  } beat_t;

  typedef struct packed {
    logic [LW-1:0] len;
    logic          bad;
  } stat_t;

  beat_t exp_q[$];
  stat_t st_q[$];

  int passed = 0;
  int total  = 0;
  int exp_good = 0;
  int exp_bad  = 0;

  int rdy_mode = 0;   // 0: always ready, 1: random, 2: stalled
  bit gap_en   = 0;
  bit last_acc;
  bit last_in_tready;
  bit p_stall;
  beat_t p_beat;

  logic [DW-1:0] fd [0:15];
  logic          fu [0:15];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic check_out();
    beat_t e;
    if (exp_q.size() == 0) begin
      check("spurious_beat", {31'd0, out_tvalid}, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("out_data", {24'd0, out_tdata}, {24'd0, e.data});
      check("out_last", {31'd0, out_tlast}, {31'd0, e.last});
      if (e.last) check("out_user_last", {31'd0, out_tuser}, {31'd0, e.user});
    end
  endtask

  task automatic check_status();
    stat_t s;
    if (st_q.size() == 0) begin
      check("spurious_status", {31'd0, frame_len_valid}, 32'd0);
    end else begin
      s = st_q.pop_front();
      check("frame_len", {16'd0, frame_len}, {16'd0, s.len});
      check("frame_bad", {31'd0, frame_bad}, {31'd0, s.bad});
    end
  endtask

  // One clock: sample handshakes just before the edge, check after it.
  task automatic cyc();
    case (rdy_mode)
      0:       out_tready = 1'b1;
      1:       out_tready = 1'($urandom_range(0, 1));
      default: out_tready = 1'b0;
    endcase
    #1;
    last_acc       = in_tvalid && in_tready;
    last_in_tready = in_tready;
    if (out_tvalid === 1'b1 && out_tready) check_out();
    p_stall = (out_tvalid === 1'b1) && !out_tready;
    p_beat  = '{data: out_tdata, last: out_tlast, user: out_tuser};
    @(posedge clk);
    @(negedge clk);
    if (p_stall) begin
      check("hold_valid", {31'd0, out_tvalid}, 32'd1);
      check("hold_beat", {22'd0, out_tdata, out_tlast, out_tuser},
            {22'd0, p_beat.data, p_beat.last, p_beat.user});
    end
    if (frame_len_valid === 1'b1) check_status();
    else check("bad_without_valid", {31'd0, frame_bad}, 32'd0);
  endtask

  // Frame-level model: forwarded = min(len, MAX), bad if cut, short or tainted.
  task automatic model_frame(input int len);
    int  fwd;
    bit  anyu;
    bit  bad;
    fwd  = (len < MAXL) ? len : MAXL;
    anyu = 0;
    for (int i = 0; i < len; i++) anyu |= fu[i];
    bad  = (len > MAXL) || (len < MINL) || anyu;
    for (int i = 0; i < fwd; i++)
      exp_q.push_back('{data: fd[i], last: (i == fwd - 1), user: (i == fwd - 1) ? bad : 1'b0});
    st_q.push_back('{len: LW'(fwd), bad: bad});
    if (bad) exp_bad++; else exp_good++;
  endtask

  task automatic drive_beat(input logic [DW-1:0] d, input logic l, input logic u, output int waits);
    waits = 0;
    if (gap_en) begin
      while ($urandom_range(0, 3) == 0) begin
        in_tvalid = 1'b0;
        cyc();
      end
    end
    in_tvalid = 1'b1;
    in_tdata  = d;
    in_tlast  = l;
    in_tuser  = u;
    forever begin
      cyc();
      if (last_acc || waits > 200) break;
      waits++;
    end
    check("accept_timeout", {31'd0, (waits > 200)}, 32'd0);
    in_tvalid = 1'b0;
  endtask

  task automatic drive_frame(input int len, input bit chk_tput);
    int w;
    for (int i = 0; i < len; i++) begin
      drive_beat(fd[i], (i == len - 1), fu[i], w);
      if (chk_tput) check("no_bubble", w, 0);
    end
  endtask

  task automatic seq_frame(input int len, input int base);
    for (int i = 0; i < len; i++) begin
      fd[i] = DW'(base + i);
      fu[i] = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    in_tvalid = 1'b0;
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    int w;
    rst = 1'b1; in_tvalid = 1'b0; in_tdata = '0; in_tlast = 1'b0; in_tuser = 1'b0;
    out_tready = 1'b1;
    @(negedge clk);

    // Reset state
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("rst_tready", {31'd0, last_in_tready}, 32'd0);
    end
    check("rst_state", {13'd0, out_tvalid, out_tlast, out_tuser, out_tdata, frame_len_valid, frame_bad},
          32'd0);
    check("rst_frame_len", {16'd0, frame_len}, 32'd0);
    rst = 1'b0;
    idle(1);

    // 3-beat good frame, one-cycle latency
    seq_frame(3, 1);
    model_frame(3);
    drive_beat(fd[0], 1'b0, 1'b0, w);
    check("latency_valid", {31'd0, out_tvalid}, 32'd1);
    check("latency_data", {24'd0, out_tdata}, 32'd1);
    drive_beat(fd[1], 1'b0, 1'b0, w);
    drive_beat(fd[2], 1'b1, 1'b0, w);
    idle(3);

    // 6-beat frame truncated at MAX, then a normal frame
    seq_frame(6, 1);  model_frame(6); drive_frame(6, 1'b0);
    seq_frame(2, 10); model_frame(2); drive_frame(2, 1'b0);
    idle(3);

    // 1-beat short frame
    fd[0] = 8'd9; fu[0] = 1'b0; model_frame(1); drive_frame(1, 1'b0);
    idle(3);

    // exactly MAX_LEN beats passes clean; tuser mid-frame taints a frame
    seq_frame(4, 20); model_frame(4); drive_frame(4, 1'b1);
    seq_frame(3, 30); fu[1] = 1'b1; model_frame(3); drive_frame(3, 1'b0);
    idle(3);

    // downstream stall mid-frame
    seq_frame(4, 40); model_frame(4);
    drive_beat(fd[0], 1'b0, 1'b0, w);
    drive_beat(fd[1], 1'b0, 1'b0, w);
    in_tvalid = 1'b1; in_tdata = fd[2]; in_tlast = 1'b0; in_tuser = 1'b0;
    rdy_mode = 2;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("stall_tready", {31'd0, last_in_tready}, 32'd0);
    end
    rdy_mode = 0;
    drive_beat(fd[2], 1'b0, 1'b0, w);
    drive_beat(fd[3], 1'b1, 1'b0, w);
    idle(3);

    // reset after beat 2 of a frame; those two beats are already out
    exp_q.push_back('{data: 8'd50, last: 1'b0, user: 1'b0});
    exp_q.push_back('{data: 8'd51, last: 1'b0, user: 1'b0});
    drive_beat(8'd50, 1'b0, 1'b0, w);
    drive_beat(8'd51, 1'b0, 1'b0, w);
    idle(2);
    rst = 1'b1;
    exp_good = 0; exp_bad = 0;
    for (int i = 0; i < 2; i++) begin
      cyc();
      check("rst2_tready", {31'd0, last_in_tready}, 32'd0);
      check("rst2_tvalid", {31'd0, out_tvalid}, 32'd0);
    end
    rst = 1'b0;
    seq_frame(2, 7); model_frame(2); drive_frame(2, 1'b1);

    // stats sequence: good (above), truncated, short, good
    seq_frame(6, 60); model_frame(6); drive_frame(6, 1'b0);
    fd[0] = 8'd70; fu[0] = 1'b0; model_frame(1); drive_frame(1, 1'b0);
    seq_frame(3, 80); model_frame(3); drive_frame(3, 1'b0);
    idle(4);
`ifdef AXIS_LEN_STATS_EN
    check("good_count", good_count, 32'd2);
    check("bad_count", bad_count, 32'd2);
`endif

    // randomized frames with gaps and random backpressure
    gap_en = 1; rdy_mode = 1;
    for (int f = 0; f < 40; f++) begin
      int len;
      len = $urandom_range(1, 7);
      for (int i = 0; i < len; i++) begin
        fd[i] = DW'($urandom);
        fu[i] = ($urandom_range(0, 9) == 0);
      end
      model_frame(len);
      drive_frame(len, 1'b0);
    end
    gap_en = 0; rdy_mode = 0;
    idle(6);

    check("beats_drained", exp_q.size(), 0);
    check("status_drained", st_q.size(), 0);
`ifdef AXIS_LEN_STATS_EN
    check("good_count_end", good_count, exp_good);
    check("bad_count_end", bad_count, exp_bad);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
